ram16_8bit_loader: RTL and testbench
====================================

# ram16_8bit_loader

Sequential program loader for the 16 x 8 SAP memory. It accepts program bytes one at a time over a valid/ready handshake and writes them to consecutive addresses from 0 up to LAST_ADDR, driving address, data and an active-low write strobe with setup and hold cycles. It can then read every location back through the memory's active-low output enable, compare each word against an internal shadow copy, and report the first mismatch. It sits between the front-panel/serial byte source and the memory, and is the write-side counterpart of the memory's read path.

## Interface
- LAST_ADDR, 4'hf: last address written; words loaded = LAST_ADDR+1.
- VERIFY, 1: 1 = readback/compare pass after load; 0 = go straight to DONE.

- clk  input  1  rising-edge clock.
- low_rst  input  1  synchronous, active-low reset.
- start  input  1  begin load; sampled only in IDLE or DONE.
- in_data  input  8  program byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- addr  output  4  memory address.
- ram_data  output tri  8  write data; 8'bzzzzzzzz except in SETUP/STROBE/HOLD.
- low_we  output  1  active-low write strobe.
- low_o_en  output  1  active-low memory output enable (readback).
- ram_q  input  8  memory read data.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE.
- error  output  1  sticky readback mismatch.
- err_addr  output  4  address of first mismatch.

## Operation
- Internal 16 x 8 shadow register file, written on each accepted byte at the current addr.
- States:
  - IDLE: start=1 -> WAIT_BYTE, addr<=0, error<=0, err_addr<=0.
  - WAIT_BYTE: in_ready=1. in_valid=1 -> latch in_data into the data register and shadow[addr], then -> SETUP.
  - SETUP: ram_data driven, low_we=1.
  - STROBE: low_we=0, ram_data driven.
  - HOLD: low_we=1, ram_data driven. If addr==LAST_ADDR: -> RD_ADDR with addr<=0 when VERIFY=1, else -> DONE. Otherwise addr<=addr+1 and -> WAIT_BYTE.
  - RD_ADDR: low_o_en=0.
  - RD_CMP: low_o_en=0; sample ram_q. If ram_q != shadow[addr] and error=0: error<=1, err_addr<=addr. If addr==LAST_ADDR -> DONE, else addr<=addr+1 and -> RD_ADDR.
  - DONE: done=1, holds addr, error and err_addr. start=1 -> WAIT_BYTE with the same initialisation as IDLE.
- start is ignored while busy. in_valid is ignored outside WAIT_BYTE (in_ready=0 there).
- Address arithmetic is 4-bit. addr never increments past LAST_ADDR, so it never wraps.
- A mismatch does not abort verification. Only the first mismatch address is kept.
- low_we and low_o_en are never both 0 in the same cycle.

## Timing
- All outputs are registered; state changes on the rising clk edge.
- Reset values (low_rst=0 at an edge): state IDLE, addr=0, ram_data=Z, low_we=1, low_o_en=1, in_ready=0, busy=0, done=0, error=0, err_addr=0.
- Reset mid-operation aborts at the next edge. low_we returns to 1 even if it was in STROBE. The shadow contents are don't-care after reset.
- Byte accepted on edge N (WAIT_BYTE, in_valid=1):
  - SETUP during N..N+1.
  - low_we=0 during N+1..N+2.
  - HOLD during N+2..N+3.
  - WAIT_BYTE again at N+3.
- Minimum 4 cycles per byte. A full 16-word load with in_valid held high takes 64 cycles from entering WAIT_BYTE.
- Verify takes 2 cycles per word, 32 cycles for 16 words. ram_q is sampled at the end of RD_CMP, after 2 cycles of low_o_en=0.
- done asserts the cycle after the final HOLD (VERIFY=0) or the final RD_CMP (VERIFY=1).

## Test plan
- Reset: hold low_rst=0 for 2 cycles mid-load -> low_we=1, ram_data=Z, addr=0, busy=0, done=0 at the next edge.
- Full load, VERIFY=1, model RAM, bytes 8'h00..8'h0f, in_valid held high:
  - exactly 16 low_we pulses, each 1 cycle, addr 0..15, data stable in SETUP/STROBE/HOLD;
  - done after 64+32 cycles; error=0.
- Stalled source: in_valid low for 5 cycles between bytes -> in_ready stays 1, no low_we pulse, addr unchanged; loading resumes correctly.
- Fault injection: model RAM forces address 4'h9 to read 8'hff and address 4'hc to read 8'h00 when written 8'h5a -> error=1, err_addr=4'h9, done=1.
- VERIFY=0, LAST_ADDR=4'h3: 4 bytes -> 4 writes, low_o_en never 0, done 16 cycles after entering WAIT_BYTE.
- Protocol edges:
  - start pulsed while busy -> ignored;
  - start in DONE -> error cleared, new load from addr 0;
  - low_we and low_o_en never both 0 (assertion).

Source files
------------

// File: rtl/ram16_8bit_loader.sv
// Sequential program loader for the 16x8 SAP memory: accepts bytes over valid/ready,
// writes them with setup/strobe/hold cycles and optionally reads back against a shadow copy.
module ram16_8bit_loader #(
  parameter logic [3:0] LAST_ADDR = 4'hf,
  parameter bit         VERIFY    = 1'b1
) (
  input  logic       clk,
  input  logic       low_rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] addr,
  output tri   [7:0] ram_data,
  output logic       low_we,
  output logic       low_o_en,
  input  logic [7:0] ram_q,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BYTE, S_SETUP, S_STROBE, S_HOLD, S_RD_ADDR, S_RD_CMP, S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] addr_reg, addr_next;
  logic       error_reg, error_next;
  logic [3:0] err_addr_reg, err_addr_next;
  logic [7:0] data_reg;
  logic [7:0] shadow [16];
  logic [7:0] shadow_q_reg;
  logic       accept;
  logic       at_last;

  logic drive_reg, low_we_reg, low_o_en_reg, in_ready_reg, busy_reg, done_reg;
  logic drive_next, low_we_next, low_o_en_next, in_ready_next, busy_next, done_next;

  assign accept  = (state_reg == S_WAIT_BYTE) && in_valid;
  assign at_last = (addr_reg == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!low_rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= 4'd0;
      error_reg    <= 1'b0;
      err_addr_reg <= 4'd0;
      drive_reg    <= 1'b0;
      low_we_reg   <= 1'b1;
      low_o_en_reg <= 1'b1;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      error_reg    <= error_next;
      err_addr_reg <= err_addr_next;
      drive_reg    <= drive_next;
      low_we_reg   <= low_we_next;
      low_o_en_reg <= low_o_en_next;
      in_ready_reg <= in_ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Shadow read is registered; addr is stable across RD_ADDR -> RD_CMP so the
  // word is ready for the compare at the end of RD_CMP.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_reg         <= in_data;
      shadow[addr_reg] <= in_data;
    end
    shadow_q_reg <= shadow[addr_reg];
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    error_next    = error_reg;
    err_addr_next = err_addr_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next    = S_WAIT_BYTE;
          addr_next     = 4'd0;
          error_next    = 1'b0;
          err_addr_next = 4'd0;
        end
      end
      S_WAIT_BYTE: if (in_valid) state_next = S_SETUP;
      S_SETUP:     state_next = S_STROBE;
      S_STROBE:    state_next = S_HOLD;
      S_HOLD: begin
        if (at_last) begin
          if (VERIFY) begin
            state_next = S_RD_ADDR;
            addr_next  = 4'd0;
          end else begin
            state_next = S_DONE;
          end
        end else begin
          addr_next  = addr_reg + 4'd1;
          state_next = S_WAIT_BYTE;
        end
      end
      S_RD_ADDR: state_next = S_RD_CMP;
      S_RD_CMP: begin
        if ((ram_q != shadow_q_reg) && !error_reg) begin
          error_next    = 1'b1;
          err_addr_next = addr_reg;
        end
        if (at_last) begin
          state_next = S_DONE;
        end else begin
          addr_next  = addr_reg + 4'd1;
          state_next = S_RD_ADDR;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops line up with the state.
  always_comb begin
    drive_next    = 1'b0;
    low_we_next   = 1'b1;
    low_o_en_next = 1'b1;
    in_ready_next = 1'b0;
    busy_next     = 1'b1;
    done_next     = 1'b0;
    case (state_next)
      S_IDLE:      busy_next = 1'b0;
      S_DONE: begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      S_WAIT_BYTE: in_ready_next = 1'b1;
      S_SETUP, S_HOLD: drive_next = 1'b1;
      S_STROBE: begin
        drive_next  = 1'b1;
        low_we_next = 1'b0;
      end
      S_RD_ADDR, S_RD_CMP: low_o_en_next = 1'b0;
      default: ;
    endcase
  end

  assign ram_data = drive_reg ? data_reg : 8'bzzzzzzzz;
  assign addr     = addr_reg;
  assign low_we   = low_we_reg;
  assign low_o_en = low_o_en_reg;
  assign in_ready = in_ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign error    = error_reg;
  assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_ram16_8bit_loader.sv
// Bench for ram16_8bit_loader: a verifying 16-word instance with a model RAM and write
// scoreboard, plus a 4-word no-verify instance driven from a per-cycle vector table.
module tb_ram16_8bit_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic low_rst;

  logic       start_a, in_valid_a, in_ready_a, low_we_a, low_o_en_a, busy_a, done_a, error_a;
  logic [7:0] in_data_a, ram_q_a;
  logic [3:0] addr_a, err_addr_a;
  tri1  [7:0] ram_data_a;

  logic       start_b, in_valid_b, in_ready_b, low_we_b, low_o_en_b, busy_b, done_b, error_b;
  logic [7:0] in_data_b;
  logic [7:0] ram_q_b = 8'h00;
  logic [3:0] addr_b, err_addr_b;
  tri1  [7:0] ram_data_b;

  ram16_8bit_loader dut_a (
    .clk(clk), .low_rst(low_rst), .start(start_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .addr(addr_a), .ram_data(ram_data_a), .low_we(low_we_a),
    .low_o_en(low_o_en_a), .ram_q(ram_q_a), .busy(busy_a), .done(done_a), .error(error_a),
    .err_addr(err_addr_a)
  );

  ram16_8bit_loader #(.LAST_ADDR(4'h3), .VERIFY(1'b0)) dut_b (
    .clk(clk), .low_rst(low_rst), .start(start_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .addr(addr_b), .ram_data(ram_data_b), .low_we(low_we_b),
    .low_o_en(low_o_en_b), .ram_q(ram_q_b), .busy(busy_b), .done(done_b), .error(error_b),
    .err_addr(err_addr_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes_a = 0;
  int oe_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model RAM for instance A, with optional stuck/corrupting locations.
  logic [7:0] mem_a [16];
  logic       fault_en = 1'b0;

  always @(posedge clk) if (!low_we_a) mem_a[addr_a] <= ram_data_a;

  always_comb begin
    ram_q_a = mem_a[addr_a];
    if (fault_en && addr_a == 4'h9) ram_q_a = 8'hff;
    else if (fault_en && addr_a == 4'hc && mem_a[4'hc] == 8'h5a) ram_q_a = 8'h00;
  end

  // Write scoreboard: expectations are pushed when a byte is offered.
  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t sb_q[$];

  logic       prev_we_a = 1'b1;
  logic [7:0] prev_bus_a = 8'hff;
  logic [7:0] strobe_bus_a = 8'hff;

  always @(negedge clk) begin
    if (!low_we_a) begin
      writes_a++;
      check("we_pulse_width", {31'd0, prev_we_a}, 32'd1);
      check("setup_data", {24'd0, ram_data_a}, {24'd0, prev_bus_a});
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %02h, expected no write", addr_a, ram_data_a);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {28'd0, addr_a}, {28'd0, e.a});
        check("wr_data", {24'd0, ram_data_a}, {24'd0, e.d});
        $display("write addr=%0h data=%02h", addr_a, ram_data_a);
      end
      strobe_bus_a = ram_data_a;
    end else if (!prev_we_a && busy_a) begin
      check("hold_data", {24'd0, ram_data_a}, {24'd0, strobe_bus_a});
    end
    if (!low_o_en_a) oe_a++;
    prev_we_a  = low_we_a;
    prev_bus_a = ram_data_a;
  end

  always @(negedge clk) begin
    checks++;
    assert (low_we_a || low_o_en_a) else begin
      errors++;
      $display("FAIL we_oe_overlap_a: low_we=%b low_o_en=%b, expected not both 0", low_we_a, low_o_en_a);
    end
    checks++;
    assert (low_we_b || low_o_en_b) else begin
      errors++;
      $display("FAIL we_oe_overlap_b: low_we=%b low_o_en=%b, expected not both 0", low_we_b, low_o_en_b);
    end
  end

  logic [7:0] load_data [16];

  // Called at a negedge. Offers nbytes from load_data; optionally stalls 5 cycles in
  // WAIT_BYTE before byte stall_idx while pulsing start (which must be ignored).
  task automatic feed(input int nbytes, input int stall_idx);
    int guard;
    for (int j = 0; j < nbytes; j++) begin
      if (j == stall_idx) begin
        in_valid_a = 1'b0;
        guard = 0;
        while (!in_ready_a && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        for (int s = 0; s < 5; s++) begin
          start_a = (s == 2);
          @(negedge clk);
          check("stall_ready", {31'd0, in_ready_a}, 32'd1);
          check("stall_addr", {28'd0, addr_a}, j);
          check("stall_busy", {31'd0, busy_a}, 32'd1);
        end
        start_a = 1'b0;
      end
      in_data_a  = load_data[j];
      in_valid_a = 1'b1;
      guard = 0;
      while (!in_ready_a && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready_a) begin
        check("feed_ready_timeout", {31'd0, in_ready_a}, 32'd1);
        return;
      end
      sb_q.push_back({j[3:0], load_data[j]});
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int c);
    int guard;
    guard = 0;
    while (!done_a && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("done_timeout", {31'd0, done_a}, 32'd1);
    c = cyc;
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_we;
    logic       exp_oe;
    logic [7:0] exp_bus;
    logic [3:0] exp_addr;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t       tbl [19];
  logic [7:0] bytes_b [4];

  initial begin
    int t0;
    int dc;
    int guard;

    bytes_b[0] = 8'h3c; bytes_b[1] = 8'ha5; bytes_b[2] = 8'h7e; bytes_b[3] = 8'h01;
    // Row 0: start; rows 1..16: four bytes with in_valid held; 17: idle in DONE; 18: restart.
    for (int i = 0; i < 19; i++) begin
      tbl[i] = '{start: 1'b0, valid: 1'b0, data: 8'h00, exp_ready: 1'b0, exp_we: 1'b1,
                 exp_oe: 1'b1, exp_bus: 8'hff, exp_addr: 4'h0, exp_busy: 1'b1, exp_done: 1'b0};
      if (i == 0) begin
        tbl[i].start = 1'b1;
        tbl[i].exp_ready = 1'b1;
      end else if (i <= 16) begin
        int j;
        int p;
        j = (i - 1) / 4;
        p = (i - 1) % 4;
        tbl[i].valid = 1'b1;
        tbl[i].data = bytes_b[j];
        tbl[i].exp_addr = j[3:0];
        if (p < 3) tbl[i].exp_bus = bytes_b[j];
        if (p == 1) tbl[i].exp_we = 1'b0;
        if (p == 3) begin
          if (j < 3) begin
            tbl[i].exp_ready = 1'b1;
            tbl[i].exp_addr = j[3:0] + 4'd1;
          end else begin
            tbl[i].exp_busy = 1'b0;
            tbl[i].exp_done = 1'b1;
          end
        end
      end else if (i == 17) begin
        tbl[i].valid = 1'b1;
        tbl[i].data = 8'h99;
        tbl[i].exp_addr = 4'h3;
        tbl[i].exp_busy = 1'b0;
        tbl[i].exp_done = 1'b1;
      end else begin
        tbl[i].start = 1'b1;
        tbl[i].exp_ready = 1'b1;
      end
    end

    low_rst = 1'b0;
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = 8'h00;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'h00;
    repeat (3) @(negedge clk);
    low_rst = 1'b1;
    @(negedge clk);

    check("rst_addr", {28'd0, addr_a}, 32'd0);
    check("rst_low_we", {31'd0, low_we_a}, 32'd1);
    check("rst_low_o_en", {31'd0, low_o_en_a}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_error", {31'd0, error_a}, 32'd0);
    check("rst_err_addr", {28'd0, err_addr_a}, 32'd0);
    check("rst_bus_z", {24'd0, ram_data_a}, 32'hff);

    // Reset during a write strobe.
    start_pulse_a();
    in_data_a = 8'h77;
    in_valid_a = 1'b1;
    sb_q.push_back({4'h0, 8'h77});
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (low_we_a && guard < 10);
    check("midrst_reached_strobe", {31'd0, low_we_a}, 32'd0);
    low_rst = 1'b0;
    in_valid_a = 1'b0;
    @(negedge clk);
    check("midrst_low_we", {31'd0, low_we_a}, 32'd1);
    check("midrst_bus_z", {24'd0, ram_data_a}, 32'hff);
    check("midrst_addr", {28'd0, addr_a}, 32'd0);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    low_rst = 1'b1;
    @(negedge clk);

    // Table-driven run of the 4-word, no-verify instance.
    for (int i = 0; i < 19; i++) begin
      start_b = tbl[i].start;
      in_valid_b = tbl[i].valid;
      in_data_b = tbl[i].data;
      @(negedge clk);
      check($sformatf("b%0d_ready", i), {31'd0, in_ready_b}, {31'd0, tbl[i].exp_ready});
      check($sformatf("b%0d_we", i), {31'd0, low_we_b}, {31'd0, tbl[i].exp_we});
      check($sformatf("b%0d_oe", i), {31'd0, low_o_en_b}, {31'd0, tbl[i].exp_oe});
      check($sformatf("b%0d_bus", i), {24'd0, ram_data_b}, {24'd0, tbl[i].exp_bus});
      check($sformatf("b%0d_addr", i), {28'd0, addr_b}, {28'd0, tbl[i].exp_addr});
      check($sformatf("b%0d_busy", i), {31'd0, busy_b}, {31'd0, tbl[i].exp_busy});
      check($sformatf("b%0d_done", i), {31'd0, done_b}, {31'd0, tbl[i].exp_done});
      $display("b row %0d: addr=%0h we=%b bus=%02h done=%b", i, addr_b, low_we_b, ram_data_b, done_b);
    end
    start_b = 1'b0;
    in_valid_b = 1'b0;

    // Full 16-word load with verify, in_valid held high.
    for (int j = 0; j < 16; j++) load_data[j] = 8'(j);
    writes_a = 0;
    oe_a = 0;
    start_pulse_a();
    t0 = cyc;
    check("full_enter_ready", {31'd0, in_ready_a}, 32'd1);
    feed(16, -1);
    wait_done(dc);
    check("full_done_cycles", dc - t0, 32'd96);
    check("full_writes", writes_a, 32'd16);
    check("full_oe_cycles", oe_a, 32'd32);
    check("full_error", {31'd0, error_a}, 32'd0);
    check("full_err_addr", {28'd0, err_addr_a}, 32'd0);
    check("full_addr", {28'd0, addr_a}, 32'hf);
    check("full_busy", {31'd0, busy_a}, 32'd0);
    $display("full load: done after %0d cycles, error=%b", dc - t0, error_a);

    // Stalled source plus an ignored start while busy.
    for (int j = 0; j < 16; j++) load_data[j] = 8'h40 + 8'(j);
    writes_a = 0;
    start_pulse_a();
    feed(16, 5);
    wait_done(dc);
    check("stall_writes", writes_a, 32'd16);
    check("stall_error", {31'd0, error_a}, 32'd0);
    $display("stalled load: writes=%0d error=%b", writes_a, error_a);

    // Fault injection: addresses 9 and c both mismatch; only 9 is reported.
    for (int j = 0; j < 16; j++) load_data[j] = 8'h20 + 8'(j);
    load_data[12] = 8'h5a;
    fault_en = 1'b1;
    start_pulse_a();
    feed(16, -1);
    wait_done(dc);
    check("fault_error", {31'd0, error_a}, 32'd1);
    check("fault_err_addr", {28'd0, err_addr_a}, 32'h9);
    check("fault_done", {31'd0, done_a}, 32'd1);
    $display("fault load: error=%b err_addr=%0h", error_a, err_addr_a);
    fault_en = 1'b0;

    // Restart from DONE clears the error and resets the address.
    in_valid_a = 1'b0;
    start_pulse_a();
    check("restart_error", {31'd0, error_a}, 32'd0);
    check("restart_err_addr", {28'd0, err_addr_a}, 32'd0);
    check("restart_addr", {28'd0, addr_a}, 32'd0);
    check("restart_ready", {31'd0, in_ready_a}, 32'd1);
    check("restart_done", {31'd0, done_a}, 32'd0);
    check("restart_busy", {31'd0, busy_a}, 32'd1);
    $display("restart: addr=%0h error=%b", addr_a, error_a);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
